// File: rtl/rat_io_responder.sv
// Peripheral responder on the RAT MCU port-I/O bus. It decodes PORT_ID, holds the
// LED, 7-seg and timer registers, returns read data on IN_PORT, and raises INTR
// from an interval timer and from button rising edges.
module rat_io_responder #(
    parameter int unsigned PRESCALE    = 100,
    parameter logic [7:0]  LED_ID      = 8'h40,
    parameter logic [7:0]  SSEG_ID     = 8'h81,
    parameter logic [7:0]  SW_ID       = 8'h20,
    parameter logic [7:0]  BTN_ID      = 8'h24,
    parameter logic [7:0]  TMR_LO_ID   = 8'hB0,
    parameter logic [7:0]  TMR_HI_ID   = 8'hB1,
    parameter logic [7:0]  TMR_CTL_ID  = 8'hB2,
    parameter logic [7:0]  INT_STAT_ID = 8'h30,
    parameter logic [7:0]  INT_ACK_ID  = 8'h31
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] PORT_ID,
    input  logic [7:0] OUT_PORT,
    input  logic       IO_STRB,
    output logic [7:0] IN_PORT,
    output logic       INTR,
    input  logic [7:0] SWITCHES,
    input  logic [3:0] BUTTONS,
    output logic [7:0] LEDS,
    output logic [7:0] SSEG_DATA
);

    localparam int unsigned PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned CNT_W   = 16;
    localparam logic [PW-1:0] PS_MAX = PW'(PRESCALE - 1);

    logic [CNT_W-1:0] reload;
    logic [CNT_W-1:0] counter;
    logic [PW-1:0]    prescaler;
    logic [2:0]       ctl;
    logic             tmr_pend;
    logic             btn_pend;
    logic [3:0]       btn_meta;
    logic [3:0]       btn_sync;
    logic [3:0]       btn_prev;

    logic wr_ctl;
    logic wr_ack;
    logic tmr_start;
    logic tmr_wrap;
    logic tmr_fire;
    logic btn_edge;

    assign wr_ctl    = IO_STRB && (PORT_ID == TMR_CTL_ID);
    assign wr_ack    = IO_STRB && (PORT_ID == INT_ACK_ID);
    assign tmr_start = wr_ctl && OUT_PORT[0] && !ctl[0];
    assign tmr_wrap  = ctl[0] && !tmr_start && (prescaler == PS_MAX);
    assign tmr_fire  = tmr_wrap && (counter == '0);
    assign btn_edge  = |(btn_sync & ~btn_prev);

    // Combinational read mux; write-only and unmapped IDs read as zero.
    always_comb begin
        IN_PORT = 8'h00;
        if (PORT_ID == SW_ID)
            IN_PORT = SWITCHES;
        else if (PORT_ID == BTN_ID)
            IN_PORT = {4'b0000, btn_sync};
        else if (PORT_ID == TMR_CTL_ID)
            IN_PORT = {5'b00000, ctl};
        else if (PORT_ID == INT_STAT_ID)
            IN_PORT = {6'b000000, tmr_pend, btn_pend};
    end

    // Strobed register writes for LED, 7-seg, reload and control.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            LEDS      <= 8'h00;
            SSEG_DATA <= 8'h00;
            reload    <= '0;
            ctl       <= 3'b000;
        end else if (IO_STRB) begin
            if (PORT_ID == LED_ID)    LEDS          <= OUT_PORT;
            if (PORT_ID == SSEG_ID)   SSEG_DATA     <= OUT_PORT;
            if (PORT_ID == TMR_LO_ID) reload[7:0]   <= OUT_PORT;
            if (PORT_ID == TMR_HI_ID) reload[15:8]  <= OUT_PORT;
            if (wr_ctl)               ctl           <= OUT_PORT[2:0];
        end
    end

    // Interval timer: enable edge restarts from reload; disabled means frozen.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            counter   <= '0;
            prescaler <= '0;
        end else if (tmr_start) begin
            counter   <= reload;
            prescaler <= '0;
        end else if (ctl[0]) begin
            if (tmr_wrap) begin
                prescaler <= '0;
                counter   <= tmr_fire ? reload : counter - CNT_W'(1);
            end else begin
                prescaler <= prescaler + PW'(1);
            end
        end
    end

    // Two-flop button synchronizer plus previous-value register for edge detect.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            btn_meta <= 4'b0000;
            btn_sync <= 4'b0000;
            btn_prev <= 4'b0000;
        end else begin
            btn_meta <= BUTTONS;
            btn_sync <= btn_meta;
            btn_prev <= btn_sync;
        end
    end

    // Pending bits (set beats ack) and the registered, masked interrupt request.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            tmr_pend <= 1'b0;
            btn_pend <= 1'b0;
            INTR     <= 1'b0;
        end else begin
            tmr_pend <= tmr_fire || (tmr_pend && !(wr_ack && OUT_PORT[1]));
            btn_pend <= btn_edge || (btn_pend && !(wr_ack && OUT_PORT[0]));
            INTR     <= (tmr_pend && ctl[1]) || (btn_pend && ctl[2]);
        end
    end

endmodule

// File: tb/tb_rat_io_responder.sv
// Directed bench for rat_io_responder with a short timer prescale.
module tb_rat_io_responder;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] PORT_ID;
    logic [7:0] OUT_PORT;
    logic       IO_STRB;
    logic [7:0] IN_PORT;
    logic       INTR;
    logic [7:0] SWITCHES;
    logic [3:0] BUTTONS;
    logic [7:0] LEDS;
    logic [7:0] SSEG_DATA;

    int pass_cnt  = 0;
    int total_cnt = 0;

    rat_io_responder #(.PRESCALE(4)) dut (
        .CLK(CLK), .RESET(RESET), .PORT_ID(PORT_ID), .OUT_PORT(OUT_PORT),
        .IO_STRB(IO_STRB), .IN_PORT(IN_PORT), .INTR(INTR), .SWITCHES(SWITCHES),
        .BUTTONS(BUTTONS), .LEDS(LEDS), .SSEG_DATA(SSEG_DATA)
    );

    always #5 CLK = ~CLK;

    // Called at a negedge; the write lands on the following posedge and the task
    // returns at the next negedge.
    task automatic io_write(input logic [7:0] id, input logic [7:0] data);
        PORT_ID  = id;
        OUT_PORT = data;
        IO_STRB  = 1'b1;
        @(negedge CLK);
        IO_STRB  = 1'b0;
        PORT_ID  = 8'h00;
    endtask

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge CLK);
    endtask

    task automatic read_port(input logic [7:0] id, output logic [7:0] val);
        PORT_ID = id;
        #1;
        val = IN_PORT;
        PORT_ID = 8'h00;
    endtask

    task automatic test_reset_init;
        RESET = 1'b1;
        #3;
        total_cnt++;
        if ({LEDS, SSEG_DATA, INTR} !== 17'h0) $display("FAIL reset_init got=%h exp=0", {LEDS, SSEG_DATA, INTR});
        else pass_cnt++;
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_led;
        logic [7:0] v;
        io_write(8'h40, 8'hA5);
        total_cnt++;
        if (LEDS !== 8'hA5) $display("FAIL led_write got=%h exp=a5", LEDS); else pass_cnt++;
        PORT_ID = 8'h40; OUT_PORT = 8'h5A; IO_STRB = 1'b0;
        @(negedge CLK);
        total_cnt++;
        if (LEDS !== 8'hA5) $display("FAIL led_nostrb got=%h exp=a5", LEDS); else pass_cnt++;
        io_write(8'h41, 8'hFF);
        total_cnt++;
        if ({LEDS, SSEG_DATA} !== 16'hA500) $display("FAIL unmapped_write got=%h exp=a500", {LEDS, SSEG_DATA});
        else pass_cnt++;
        io_write(8'h81, 8'h3C);
        total_cnt++;
        if (SSEG_DATA !== 8'h3C) $display("FAIL sseg_write got=%h exp=3c", SSEG_DATA); else pass_cnt++;
        read_port(8'h81, v);
        total_cnt++;
        if (v !== 8'h00) $display("FAIL sseg_read got=%h exp=00", v); else pass_cnt++;
        @(negedge CLK);
    endtask

    task automatic test_read_mux;
        logic [7:0] v;
        SWITCHES = 8'h3C;
        read_port(8'h20, v);
        total_cnt++;
        if (v !== 8'h3C) $display("FAIL read_sw got=%h exp=3c", v); else pass_cnt++;
        read_port(8'h55, v);
        total_cnt++;
        if (v !== 8'h00) $display("FAIL read_unmapped got=%h exp=00", v); else pass_cnt++;
        @(negedge CLK);
        io_write(8'hB2, 8'hFE);
        read_port(8'hB2, v);
        total_cnt++;
        if (v !== 8'h06) $display("FAIL ctl_readback got=%h exp=06", v); else pass_cnt++;
        @(negedge CLK);
        io_write(8'hB2, 8'h00);
    endtask

    task automatic test_timer;
        logic [7:0] v;
        io_write(8'hB0, 8'h02);
        io_write(8'hB1, 8'h00);
        io_write(8'hB2, 8'h03);
        wait_neg(11);
        read_port(8'h30, v);
        total_cnt++;
        if (v !== 8'h00 || INTR !== 1'b0) $display("FAIL tmr_early stat=%h intr=%b exp=00/0", v, INTR); else pass_cnt++;
        @(negedge CLK);
        read_port(8'h30, v);
        total_cnt++;
        if (v !== 8'h02 || INTR !== 1'b0) $display("FAIL tmr_expire stat=%h intr=%b exp=02/0", v, INTR); else pass_cnt++;
        @(negedge CLK);
        total_cnt++;
        if (INTR !== 1'b1) $display("FAIL tmr_intr got=%b exp=1", INTR); else pass_cnt++;
        io_write(8'h31, 8'h02);
        @(negedge CLK);
        total_cnt++;
        if (INTR !== 1'b0) $display("FAIL tmr_ack got=%b exp=0", INTR); else pass_cnt++;
        wait_neg(8);
        read_port(8'h30, v);
        total_cnt++;
        if (v !== 8'h00) $display("FAIL tmr_second_early got=%h exp=00", v); else pass_cnt++;
        @(negedge CLK);
        read_port(8'h30, v);
        total_cnt++;
        if (v !== 8'h02) $display("FAIL tmr_second got=%h exp=02", v); else pass_cnt++;
        @(negedge CLK);
        total_cnt++;
        if (INTR !== 1'b1) $display("FAIL tmr_second_intr got=%b exp=1", INTR); else pass_cnt++;
        io_write(8'hB2, 8'h00);
        io_write(8'h31, 8'h02);
        @(negedge CLK);
        read_port(8'h30, v);
        total_cnt++;
        if (v !== 8'h00 || INTR !== 1'b0) $display("FAIL tmr_stop stat=%h intr=%b exp=00/0", v, INTR); else pass_cnt++;
        @(negedge CLK);
    endtask

    task automatic test_disable;
        logic [7:0] v;
        io_write(8'hB2, 8'h01);
        wait_neg(5);
        io_write(8'hB2, 8'h00);
        wait_neg(30);
        read_port(8'h30, v);
        total_cnt++;
        if (v !== 8'h00) $display("FAIL tmr_frozen got=%h exp=00", v); else pass_cnt++;
        @(negedge CLK);
        io_write(8'hB2, 8'h03);
        wait_neg(11);
        read_port(8'h30, v);
        total_cnt++;
        if (v !== 8'h00) $display("FAIL tmr_restart_early got=%h exp=00", v); else pass_cnt++;
        @(negedge CLK);
        read_port(8'h30, v);
        total_cnt++;
        if (v !== 8'h02) $display("FAIL tmr_restart got=%h exp=02", v); else pass_cnt++;
        @(negedge CLK);
        total_cnt++;
        if (INTR !== 1'b1) $display("FAIL tmr_restart_intr got=%b exp=1", INTR); else pass_cnt++;
        io_write(8'hB2, 8'h00);
        io_write(8'h31, 8'h02);
        @(negedge CLK);
    endtask

    task automatic test_button;
        logic [7:0] v;
        BUTTONS = 4'b0100;
        wait_neg(2);
        read_port(8'h30, v);
        total_cnt++;
        if (v !== 8'h00) $display("FAIL btn_early got=%h exp=00", v); else pass_cnt++;
        @(negedge CLK);
        read_port(8'h30, v);
        total_cnt++;
        if (v !== 8'h01) $display("FAIL btn_pend got=%h exp=01", v); else pass_cnt++;
        read_port(8'h24, v);
        total_cnt++;
        if (v !== 8'h04) $display("FAIL btn_read got=%h exp=04", v); else pass_cnt++;
        @(negedge CLK);
        total_cnt++;
        if (INTR !== 1'b0) $display("FAIL btn_masked got=%b exp=0", INTR); else pass_cnt++;
        BUTTONS = 4'b0000;
        io_write(8'hB2, 8'h04);
        @(negedge CLK);
        total_cnt++;
        if (INTR !== 1'b1) $display("FAIL btn_intr got=%b exp=1", INTR); else pass_cnt++;
        io_write(8'h31, 8'h01);
        read_port(8'h30, v);
        total_cnt++;
        if (v !== 8'h00) $display("FAIL btn_ack got=%h exp=00", v); else pass_cnt++;
        @(negedge CLK);
        BUTTONS = 4'b0010;
        wait_neg(2);
        io_write(8'h31, 8'h01);
        read_port(8'h30, v);
        total_cnt++;
        if (v !== 8'h01) $display("FAIL btn_set_wins got=%h exp=01", v); else pass_cnt++;
        BUTTONS = 4'b0000;
        @(negedge CLK);
        io_write(8'h31, 8'h01);
        @(negedge CLK);
        total_cnt++;
        if (INTR !== 1'b0) $display("FAIL btn_final_ack got=%b exp=0", INTR); else pass_cnt++;
        io_write(8'hB2, 8'h00);
    endtask

    task automatic test_reset_midrun;
        logic [7:0] v;
        io_write(8'h40, 8'h77);
        io_write(8'hB0, 8'h00);
        io_write(8'hB2, 8'h03);
        wait_neg(6);
        total_cnt++;
        if (INTR !== 1'b1) $display("FAIL pre_reset_intr got=%b exp=1", INTR); else pass_cnt++;
        #2 RESET = 1'b1;
        #1;
        total_cnt++;
        if ({LEDS, SSEG_DATA, INTR} !== 17'h0) $display("FAIL reset_midrun got=%h exp=0", {LEDS, SSEG_DATA, INTR});
        else pass_cnt++;
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        read_port(8'h30, v);
        total_cnt++;
        if (v !== 8'h00) $display("FAIL reset_stat got=%h exp=00", v); else pass_cnt++;
        read_port(8'hB2, v);
        total_cnt++;
        if (v !== 8'h00) $display("FAIL reset_ctl got=%h exp=00", v); else pass_cnt++;
        wait_neg(10);
        total_cnt++;
        if (INTR !== 1'b0) $display("FAIL reset_no_intr got=%b exp=0", INTR); else pass_cnt++;
    endtask

    initial begin
        PORT_ID  = 8'h00;
        OUT_PORT = 8'h00;
        IO_STRB  = 1'b0;
        SWITCHES = 8'h00;
        BUTTONS  = 4'b0000;
        test_reset_init();
        test_led();
        test_read_mux();
        test_timer();
        test_disable();
        test_button();
        test_reset_midrun();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/rat_io_responder.md
Name: rat_io_responder

Overview:
- Peripheral-side responder for the RAT MCU port-I/O bus.
- Decodes PORT_ID, latches MCU writes qualified by IO_STRB into output registers, and returns read data on IN_PORT.
- Raises INTR from an interval timer and a button-edge detector.
- Sits between the MCU and the board I/O (LEDs, 7-seg, switches, buttons).

Parameters:
- PRESCALE, 100, CLK cycles per timer tick (≥1)
- LED_ID, 8'h40, write port for LED register
- SSEG_ID, 8'h81, write port for 7-seg data register
- SW_ID, 8'h20, read port for switches
- BTN_ID, 8'h24, read port for synchronized buttons
- TMR_LO_ID, 8'hB0, write port for reload[7:0]
- TMR_HI_ID, 8'hB1, write port for reload[15:8]
- TMR_CTL_ID, 8'hB2, read/write port for control register
- INT_STAT_ID, 8'h30, read port for pending bits
- INT_ACK_ID, 8'h31, write port that clears pending bits

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- PORT_ID  in  8  port address from MCU
- OUT_PORT  in  8  write data from MCU
- IO_STRB  in  1  one-cycle write strobe from MCU
- IN_PORT  out  8  read data to MCU
- INTR  out  1  interrupt request to MCU
- SWITCHES  in  8  board switches (static)
- BUTTONS  in  4  board buttons (asynchronous)
- LEDS  out  8  LED register
- SSEG_DATA  out  8  7-seg data register

Behaviour:
- Reset (asynchronous, immediate):
  - LEDS=0, SSEG_DATA=0, reload=16'h0000, ctl=0, counter=0, prescaler=0, pending=2'b00, INTR=0.
  - Button synchronizer and edge flops cleared.
  - Reset mid-count abandons the count; no interrupt is produced.
- Writes:
  - Occur on the rising CLK edge where IO_STRB=1; the register addressed by PORT_ID takes OUT_PORT.
  - Writes to unmapped IDs are ignored.
  - Write results are visible the next cycle.
- ctl register:
  - bit0 TMR_EN, bit1 TMR_IE, bit2 BTN_IE; bits 7:3 read back as 0.
- Reads:
  - IN_PORT is combinational from PORT_ID; IO_STRB is not required.
  - SW_ID → SWITCHES.
  - BTN_ID → {4'b0, btn_sync}.
  - TMR_CTL_ID → {5'b0, ctl[2:0]}.
  - INT_STAT_ID → {6'b0, tmr_pend, btn_pend}.
  - Any other ID → 8'h00. Write-only registers are not readable.
- Button path:
  - 2-flop synchronizer per bit, then a registered previous value.
  - A rising edge on any synchronized bit sets btn_pend.
  - Latency: BUTTONS rise to btn_pend=1 is 3 CLK edges.
- Timer:
  - A TMR_CTL write that changes TMR_EN 0→1 loads counter←reload and clears the prescaler.
  - While TMR_EN=1, the prescaler counts 0..PRESCALE-1 and wraps.
  - At the wrap edge: if counter==0, set tmr_pend and counter←reload; else counter←counter-1.
  - Period is (reload+1)*PRESCALE cycles; reload=0 fires every tick.
  - TMR_EN=0 freezes counter and prescaler.
  - Writes to reload during a run take effect at the next reload.
- Interrupt:
  - INTR = (tmr_pend & TMR_IE) | (btn_pend & BTN_IE), registered (one-cycle latency from pending/mask change).
  - Pending bits set even when masked, and are visible in INT_STAT.
  - An INT_ACK write clears each pending bit whose OUT_PORT bit is 1 (bit0 btn, bit1 tmr).
  - A set event in the same cycle as its clear: set wins (pending stays 1).
  - INTR stays high until acked or masked; there is no auto-clear.

Test Plan:
- Reset check: assert RESET mid-run with tmr_pend=1 → all outputs 0 immediately; INT_STAT reads 8'h00 after release.
- LED write: PORT_ID=8'h40, OUT_PORT=8'hA5, IO_STRB=1 for 1 cycle → LEDS=8'hA5 next cycle. Same write with IO_STRB=0 → LEDS unchanged. PORT_ID=8'h41 → nothing changes.
- Read mux: SWITCHES=8'h3C with PORT_ID=8'h20 → IN_PORT=8'h3C same cycle. PORT_ID=8'h55 → IN_PORT=8'h00.
- Timer: PRESCALE=4, write reload=16'h0002, ctl=8'h03 → INTR rises 12 cycles after enable (+1 register cycle). INT_ACK write 8'h02 → INTR=0, and it rises again 12 cycles after the previous expiry.
- Button: pulse BUTTONS[2] high with BTN_IE=0 → INT_STAT=8'h01, INTR=0. Set ctl=8'h04 → INTR=1. Ack 8'h01 in the same cycle as a new edge → btn_pend stays 1.
- Masking and disable: TMR_EN 1→0 mid-count → counter frozen, no tmr_pend. Re-enable → full period restarts from reload.
